octave_power_analyzer: RTL and testbench
========================================

Name: octave_power_analyzer

Overview:
Consumer-side counterpart to the pink noise source: measures the per-octave power of a sample stream so the 1/f slope can be checked in-system.
- Haar decimation cascade of NUM_OCT stages; each stage squares and accumulates its detail coefficient over a fixed window.
- At window end, per-octave energies are banked and streamed out over a valid/ready port.
- Sits on the same clk_en sample strobe as the noise source.

Parameters:
WIDTH, 18, sample width (signed).
NUM_OCT, 8, number of octave stages (1..15).
WIN_LOG2, 12, window = 2^WIN_LOG2 input samples; must be >= NUM_OCT.
ACC_W, 48, accumulator/result width; must be >= 36.

Ports:
clk  in  1  clock.
rst  in  1  reset, asynchronous, active-high.
clk_en  in  1  sample strobe; sample_in accepted when high.
sample_in  in  WIDTH  signed input sample.
clear  in  1  synchronous soft clear, same effect as rst.
band_valid  out  1  result word valid.
band_ready  in  1  downstream accepts result when high with band_valid.
band_idx  out  4  octave index of band_power (0 = highest octave).
band_power  out  ACC_W  unsigned summed squared detail for that octave.
overrun  out  1  sticky: a window's results were dropped.

Behaviour:
- Reset/clear: band_valid=0, band_idx=0, band_power=0, overrun=0; accumulators, pair flags, tags and sample counter=0; output FSM to IDLE. Clear has priority over clk_en in the same cycle.
- Stage k receives input x with a last tag:
  - Stage 0 receives sample_in on clk_en.
  - Stage k>0 receives the registered forward of stage k-1, one cycle after stage k-1 completes a pair.
- Stage k pair logic:
  - Flag 0: store p_k=x, set flag.
  - Flag 1: d=p_k-x (WIDTH+1 bits signed); a=(p_k+x)>>>1 (floor, WIDTH bits); acc_k += d*d, saturating at all-ones; clear flag; forward a with the incoming tag next cycle.
- Window count: counter of accepted samples, wraps at 2^WIN_LOG2. The sample accepted when count = 2^WIN_LOG2-1 carries last=1; the tag ripples up with forwarded averages.
- Banking: when stage k completes a pair whose input has last=1, bank_k <= sat(acc_k + d*d) and acc_k <= 0 in the same cycle. Stage k banks at cycle T_last+k. The next window's samples accumulate normally in the following cycles, so no samples are lost.
- Drop decision at T_last:
  - Output FSM not IDLE: overrun <= 1, and the window's banking is suppressed via a drop bit carried with the tag. Accumulators are still cleared.
  - Output FSM IDLE: a SEND is scheduled.
- Output FSM:
  - IDLE -> SEND at cycle T_last+NUM_OCT (band_valid rises that cycle), unless dropped.
  - SEND presents band_idx=i, band_power=bank_i, starting at i=0.
  - On band_valid & band_ready: i+1; after i=NUM_OCT-1 -> IDLE, band_valid=0 next cycle.
  - While band_valid & !band_ready, idx and power hold stable.
- Throughput: clk_en may be high every cycle. Stage k gets at most one input per 2 cycles, so there are no collisions.
- overrun clears only on rst/clear.

Decomposition:
Shared package (octave_analyzer_pkg):
- IDX_W=4.
- FSM state encoding IDLE/SEND.
- Saturating-add helper function.

Sub-module haar_octave_stage (one per octave, generate loop):
- Holds p_k, flag, acc_k and bank_k.
- Ports: in_valid/in_data/in_last/in_drop, out_valid/out_data/out_last/out_drop, bank output.
- Top module holds the sample counter, output FSM and overrun.

Test Plan:
Bench parameters NUM_OCT=4, WIN_LOG2=6, ACC_W=48, clk_en every 4th cycle, band_ready=1 unless stated.
1. Reset: assert rst mid-window -> all outputs 0 immediately; no band_valid until 64 further samples accepted.
2. DC 1000 for 64 samples -> 4 words, idx 0,1,2,3, power 0 each; band_valid rises exactly NUM_OCT cycles after the 64th clk_en.
3. Alternating +100,-100 for 64 samples -> idx0 power=32*40000=1280000; idx1..3 power 0.
4. Pattern 3 with band_ready low 5 cycles on idx1 -> idx/power held stable; sequence completes unchanged after release.
5. band_ready held low through the entire next window, then released -> overrun=1; first window's 4 words delivered; second window's results absent; third window reported normally.
6. ACC_W=40, alternating +131071,-131072 for 64 samples -> idx0 power = 2^40-1 (saturated); no wrap.

Source files
------------

// File: rtl/octave_analyzer_pkg.sv
// Shared types and helpers for the octave power analyzer: output FSM encoding,
// band index width and a saturating accumulator add.
package octave_analyzer_pkg;

  localparam int IDX_W = 4;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } out_state_e;

  // Operands are carried in 64 bits, so accumulators may be at most 64 bits wide.
  function automatic logic [63:0] sat_add(input logic [63:0] a, input logic [63:0] b,
                                          input int unsigned w);
    logic [64:0] sum;
    logic [64:0] lim;
    sum = {1'b0, a} + {1'b0, b};
    lim = (65'd1 << w) - 65'd1;
    if (sum > lim) begin
      sat_add = lim[63:0];
    end else begin
      sat_add = sum[63:0];
    end
  endfunction

endpackage

// File: rtl/haar_octave_stage.sv
// One Haar octave: pairs incoming samples, accumulates squared detail and
// forwards the floor average (with its window tag) to the next octave.
module haar_octave_stage
  import octave_analyzer_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int ACC_W = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    in_valid,
  input  logic signed [WIDTH-1:0] in_data,
  input  logic                    in_last,
  input  logic                    in_drop,
  output logic                    out_valid,
  output logic signed [WIDTH-1:0] out_data,
  output logic                    out_last,
  output logic                    out_drop,
  output logic [ACC_W-1:0]        bank
);

  logic signed [WIDTH-1:0]   p_r;
  logic                      flag_r;
  logic [ACC_W-1:0]          acc_r;
  logic [ACC_W-1:0]          bank_r;
  logic                      out_valid_r;
  logic signed [WIDTH-1:0]   out_data_r;
  logic                      out_last_r;
  logic                      out_drop_r;

  logic signed [WIDTH:0]     diff_s;
  logic signed [WIDTH:0]     pair_sum_s;
  logic signed [2*WIDTH+1:0] sq_s;
  logic [ACC_W-1:0]          acc_next_s;

  assign diff_s     = (WIDTH+1)'(p_r) - (WIDTH+1)'(in_data);
  assign pair_sum_s = (WIDTH+1)'(p_r) + (WIDTH+1)'(in_data);
  assign sq_s       = (2*WIDTH+2)'(diff_s) * (2*WIDTH+2)'(diff_s);
  assign acc_next_s = ACC_W'(sat_add(64'(acc_r), 64'($unsigned(sq_s)), ACC_W));

  // Pair state, accumulator, bank and forward register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_r         <= {WIDTH{1'b0}};
      flag_r      <= 1'b0;
      acc_r       <= {ACC_W{1'b0}};
      bank_r      <= {ACC_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_last_r  <= 1'b0;
      out_drop_r  <= 1'b0;
    end else if (clear) begin
      p_r         <= {WIDTH{1'b0}};
      flag_r      <= 1'b0;
      acc_r       <= {ACC_W{1'b0}};
      bank_r      <= {ACC_W{1'b0}};
      out_valid_r <= 1'b0;
      out_data_r  <= {WIDTH{1'b0}};
      out_last_r  <= 1'b0;
      out_drop_r  <= 1'b0;
    end else begin
      out_valid_r <= 1'b0;
      if (in_valid) begin
        if (!flag_r) begin
          p_r    <= in_data;
          flag_r <= 1'b1;
        end else begin
          flag_r      <= 1'b0;
          out_valid_r <= 1'b1;
          out_data_r  <= pair_sum_s[WIDTH:1];
          out_last_r  <= in_last;
          out_drop_r  <= in_drop;
          // Window boundary: the closing pair lands in the bank, the next window starts from zero.
          if (in_last) begin
            acc_r <= {ACC_W{1'b0}};
            if (!in_drop) begin
              bank_r <= acc_next_s;
            end
          end else begin
            acc_r <= acc_next_s;
          end
        end
      end
    end
  end

  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;
  assign out_last  = out_last_r;
  assign out_drop  = out_drop_r;
  assign bank      = bank_r;

endmodule

// File: rtl/octave_power_analyzer.sv
// Per-octave power meter: Haar cascade of octave stages, window counter and a
// valid/ready streamer that reports each window's banked energies.
module octave_power_analyzer
  import octave_analyzer_pkg::*;
#(
  parameter int WIDTH    = 18,
  parameter int NUM_OCT  = 8,
  parameter int WIN_LOG2 = 12,
  parameter int ACC_W    = 48
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clk_en,
  input  logic signed [WIDTH-1:0] sample_in,
  input  logic                    clear,
  output logic                    band_valid,
  input  logic                    band_ready,
  output logic [IDX_W-1:0]        band_idx,
  output logic [ACC_W-1:0]        band_power,
  output logic                    overrun
);

  localparam int NBANK = 2 ** IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OCT - 1);

  logic [WIN_LOG2-1:0]     count_r;
  out_state_e              state_r;
  logic [IDX_W-1:0]        idx_r;
  logic                    band_valid_r;
  logic [ACC_W-1:0]        band_power_r;
  logic                    overrun_r;

  logic                    win_last_s;
  logic                    busy_s;
  logic                    chain_valid_s [NUM_OCT+1];
  logic signed [WIDTH-1:0] chain_data_s  [NUM_OCT+1];
  logic                    chain_last_s  [NUM_OCT+1];
  logic                    chain_drop_s  [NUM_OCT+1];
  logic [ACC_W-1:0]        bank_s        [NBANK];

  assign win_last_s = &count_r;
  // A window closing while the previous one is still streaming gets tagged as dropped.
  assign busy_s     = (state_r != ST_IDLE);

  assign chain_valid_s[0] = clk_en;
  assign chain_data_s[0]  = sample_in;
  assign chain_last_s[0]  = win_last_s;
  assign chain_drop_s[0]  = busy_s;

  for (genvar k = 0; k < NUM_OCT; k++) begin : g_stage
    haar_octave_stage #(
      .WIDTH(WIDTH),
      .ACC_W(ACC_W)
    ) u_stage (
      .clk      (clk),
      .rst      (rst),
      .clear    (clear),
      .in_valid (chain_valid_s[k]),
      .in_data  (chain_data_s[k]),
      .in_last  (chain_last_s[k]),
      .in_drop  (chain_drop_s[k]),
      .out_valid(chain_valid_s[k+1]),
      .out_data (chain_data_s[k+1]),
      .out_last (chain_last_s[k+1]),
      .out_drop (chain_drop_s[k+1]),
      .bank     (bank_s[k])
    );
  end

  for (genvar k = NUM_OCT; k < NBANK; k++) begin : g_pad
    assign bank_s[k] = {ACC_W{1'b0}};
  end

  // Accepted-sample counter; wraps once per window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= {WIN_LOG2{1'b0}};
    end else if (clear) begin
      count_r <= {WIN_LOG2{1'b0}};
    end else if (clk_en) begin
      count_r <= count_r + WIN_LOG2'(1);
    end
  end

  // Sticky overrun flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overrun_r <= 1'b0;
    end else if (clear) begin
      overrun_r <= 1'b0;
    end else if (clk_en && win_last_s && busy_s) begin
      overrun_r <= 1'b1;
    end
  end

  // Output streamer; SEND starts when the top octave's closing tag emerges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      idx_r        <= {IDX_W{1'b0}};
      band_valid_r <= 1'b0;
      band_power_r <= {ACC_W{1'b0}};
    end else if (clear) begin
      state_r      <= ST_IDLE;
      idx_r        <= {IDX_W{1'b0}};
      band_valid_r <= 1'b0;
      band_power_r <= {ACC_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (chain_valid_s[NUM_OCT] && chain_last_s[NUM_OCT] && !chain_drop_s[NUM_OCT]) begin
            state_r      <= ST_SEND;
            idx_r        <= {IDX_W{1'b0}};
            band_valid_r <= 1'b1;
            band_power_r <= bank_s[0];
          end
        end
        ST_SEND: begin
          if (band_valid_r && band_ready) begin
            if (idx_r == LAST_IDX) begin
              state_r      <= ST_IDLE;
              idx_r        <= {IDX_W{1'b0}};
              band_valid_r <= 1'b0;
              band_power_r <= {ACC_W{1'b0}};
            end else begin
              idx_r        <= idx_r + IDX_W'(1);
              band_power_r <= bank_s[idx_r + IDX_W'(1)];
            end
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          idx_r        <= {IDX_W{1'b0}};
          band_valid_r <= 1'b0;
          band_power_r <= {ACC_W{1'b0}};
        end
      endcase
    end
  end

  assign band_valid = band_valid_r;
  assign band_idx   = idx_r;
  assign band_power = band_power_r;
  assign overrun    = overrun_r;

endmodule

// File: tb/tb_octave_power_analyzer.sv
// Scoreboard bench: two analyzers (48- and 40-bit accumulators) share stimulus;
// expected words come from a plain-arithmetic Haar energy model.
module tb_octave_power_analyzer;

  localparam int WIDTH    = 18;
  localparam int NUM_OCT  = 4;
  localparam int WIN_LOG2 = 6;
  localparam int WIN      = 64;
  localparam int ACC_A    = 48;
  localparam int ACC_B    = 40;

  typedef struct {
    int          idx;
    logic [63:0] power;
  } word_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b0;
  logic clear = 1'b0;
  logic band_ready = 1'b1;
  logic signed [WIDTH-1:0] sample_in = 18'sd0;

  logic             bv_a, bv_b, ov_a, ov_b;
  logic [3:0]       bi_a, bi_b;
  logic [ACC_A-1:0] bp_a;
  logic [ACC_B-1:0] bp_b;

  int    cyc = 0;
  int    errors = 0;
  int    checks = 0;
  int    last_cyc = 0;
  word_t q_a[$];
  word_t q_b[$];
  int    win_buf[WIN];
  int    win_n = 0;
  logic  exp_ov = 1'b0;
  logic  hold_low = 1'b0;
  logic  stall_arm = 1'b0;
  int    stall_cnt = 0;

  octave_power_analyzer #(.WIDTH(WIDTH), .NUM_OCT(NUM_OCT), .WIN_LOG2(WIN_LOG2), .ACC_W(ACC_A)) dut_a (
    .clk(clk), .rst(rst), .clk_en(clk_en), .sample_in(sample_in), .clear(clear),
    .band_valid(bv_a), .band_ready(band_ready), .band_idx(bi_a), .band_power(bp_a), .overrun(ov_a)
  );

  octave_power_analyzer #(.WIDTH(WIDTH), .NUM_OCT(NUM_OCT), .WIN_LOG2(WIN_LOG2), .ACC_W(ACC_B)) dut_b (
    .clk(clk), .rst(rst), .clk_en(clk_en), .sample_in(sample_in), .clear(clear),
    .band_valid(bv_b), .band_ready(band_ready), .band_idx(bi_b), .band_power(bp_b), .overrun(ov_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [63:0] sat(input longint v, input int w);
    longint m;
    m = (longint'(1) << w) - 1;
    return (v > m) ? 64'(m) : 64'(v);
  endfunction

  function automatic int pat(input int mode, input int i);
    case (mode)
      0:       return 1000;
      1:       return (i % 2 == 0) ? 100 : -100;
      3:       return (i % 2 == 0) ? 131071 : -131072;
      default: return int'($urandom_range(0, 262143)) - 131072;
    endcase
  endfunction

  // Window complete: octave energies from repeated pair differences/floor averages.
  task automatic finish_window();
    longint e[NUM_OCT];
    int     cur[WIN];
    int     n;
    word_t  w;
    cur = win_buf;
    n = WIN;
    for (int k = 0; k < NUM_OCT; k++) begin
      e[k] = 0;
      for (int i = 0; i < n / 2; i++) begin
        longint d;
        d = longint'(cur[2*i]) - longint'(cur[2*i+1]);
        e[k] += d * d;
        cur[i] = (cur[2*i] + cur[2*i+1]) >>> 1;
      end
      n = n / 2;
    end
    if (q_a.size() != 0) begin
      exp_ov = 1'b1;
    end else begin
      for (int k = 0; k < NUM_OCT; k++) begin
        w.idx = k;
        w.power = sat(e[k], ACC_A);
        q_a.push_back(w);
        w.power = sat(e[k], ACC_B);
        q_b.push_back(w);
      end
    end
    last_cyc = cyc;
    check("overrun_a", 64'(ov_a), 64'(exp_ov));
    check("overrun_b", 64'(ov_b), 64'(exp_ov));
    win_n = 0;
  endtask

  task automatic drive_sample(input int v);
    @(negedge clk);
    clk_en = 1'b1;
    sample_in = WIDTH'(v);
    @(negedge clk);
    clk_en = 1'b0;
    win_buf[win_n] = v;
    win_n++;
    if (win_n == WIN) finish_window();
    repeat (2) @(negedge clk);
  endtask

  task automatic run_window(input int mode);
    for (int i = 0; i < WIN; i++) drive_sample(pat(mode, i));
  endtask

  // band_ready: held low on request, or a one-shot 5-cycle stall on idx 1.
  initial forever begin
    @(posedge clk);
    #1;
    if (hold_low) begin
      band_ready = 1'b0;
    end else if (stall_cnt > 0) begin
      band_ready = 1'b0;
      stall_cnt--;
    end else if (stall_arm && bv_a && bi_a == 4'd1) begin
      stall_arm = 1'b0;
      band_ready = 1'b0;
      stall_cnt = 4;
    end else begin
      band_ready = 1'b1;
    end
  end

  // Monitor for the 48-bit analyzer: scoreboard pop, hold stability, rise latency.
  initial begin
    logic prev_v, prev_stall;
    logic [3:0] prev_i;
    logic [ACC_A-1:0] prev_p;
    word_t w;
    prev_v = 1'b0;
    prev_stall = 1'b0;
    prev_i = 4'd0;
    prev_p = 48'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_v = 1'b0;
        prev_stall = 1'b0;
      end else begin
        if (bv_a) begin
          if (prev_stall) begin
            check("hold_idx", 64'(bi_a), 64'(prev_i));
            check("hold_power", 64'(bp_a), 64'(prev_p));
          end
          if (!prev_v) check("rise_latency", 64'(cyc - last_cyc), 64'(NUM_OCT));
          if (band_ready) begin
            if (q_a.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_word_a: got idx %0d power %0d, expected none", bi_a, bp_a);
            end else begin
              w = q_a.pop_front();
              check("idx_a", 64'(bi_a), 64'(w.idx));
              check("power_a", 64'(bp_a), w.power);
            end
          end
        end
        prev_v = bv_a;
        prev_stall = bv_a && !band_ready;
        prev_i = bi_a;
        prev_p = bp_a;
      end
    end
  end

  // Monitor for the 40-bit (saturating) analyzer.
  initial begin
    word_t w;
    forever begin
      @(negedge clk);
      if (!rst && bv_b && band_ready) begin
        if (q_b.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word_b: got idx %0d power %0d, expected none", bi_b, bp_b);
        end else begin
          w = q_b.pop_front();
          check("idx_b", 64'(bi_b), 64'(w.idx));
          check("power_b", 64'(bp_b), w.power);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_valid_a", 64'(bv_a), 64'd0);
    check("rst_idx_a", 64'(bi_a), 64'd0);
    check("rst_power_a", 64'(bp_a), 64'd0);
    check("rst_overrun_a", 64'(ov_a), 64'd0);
    check("rst_valid_b", 64'(bv_b), 64'd0);

    run_window(0);                       // DC: zero detail everywhere
    repeat (20) @(negedge clk);
    run_window(1);                       // alternating +-100
    repeat (20) @(negedge clk);
    stall_arm = 1'b1;                    // same, stalled on idx 1
    run_window(1);
    repeat (30) @(negedge clk);
    for (int r = 0; r < 3; r++) begin
      run_window(2);
      repeat (20) @(negedge clk);
    end
    run_window(3);                       // full-scale alternation saturates 40-bit
    repeat (20) @(negedge clk);

    hold_low = 1'b1;                     // second window dropped while first is stuck
    run_window(1);
    run_window(2);
    hold_low = 1'b0;
    repeat (20) @(negedge clk);
    run_window(2);
    repeat (20) @(negedge clk);

    for (int i = 0; i < 10; i++) drive_sample(pat(2, i));
    @(negedge clk);                      // clear wins over a simultaneous strobe
    clear = 1'b1;
    clk_en = 1'b1;
    sample_in = 18'sd5;
    @(negedge clk);
    clear = 1'b0;
    clk_en = 1'b0;
    win_n = 0;
    exp_ov = 1'b0;
    check("clear_overrun_a", 64'(ov_a), 64'd0);
    check("clear_valid_a", 64'(bv_a), 64'd0);
    run_window(2);
    repeat (20) @(negedge clk);

    hold_low = 1'b1;                     // async reset while stalled and overrun set
    run_window(1);
    run_window(2);
    for (int i = 0; i < 20; i++) drive_sample(pat(2, i));
    check("stalled_valid_a", 64'(bv_a), 64'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_valid_a", 64'(bv_a), 64'd0);
    check("arst_idx_a", 64'(bi_a), 64'd0);
    check("arst_power_a", 64'(bp_a), 64'd0);
    check("arst_overrun_a", 64'(ov_a), 64'd0);
    check("arst_power_b", 64'(bp_b), 64'd0);
    q_a.delete();
    q_b.delete();
    win_n = 0;
    exp_ov = 1'b0;
    hold_low = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_window(1);
    repeat (20) @(negedge clk);
    run_window(2);

    for (int t = 0; t < 200 && (q_a.size() != 0 || q_b.size() != 0); t++) @(negedge clk);
    check("drain_a", 64'(q_a.size()), 64'd0);
    check("drain_b", 64'(q_b.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
